// File: rtl/axis_averager_sequencer.sv
// Run controller in front of axis_complex_averager: gates and frame-aligns the input stream,
// holds the averager in reset while idle and counts averaged results for each run.
module axis_averager_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_LEN_LOG    = 10,
  parameter int RUN_CNT_WIDTH    = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [4:0]                  cfg_log_count,
  input  logic [RUN_CNT_WIDTH-1:0]    cfg_num_runs,
  input  logic                        cmd_start,
  input  logic                        cmd_stop,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  input  logic                        S_AXIS_tlast,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  input  logic                        mon_tvalid,
  input  logic                        mon_tready,
  input  logic                        mon_tlast,
  output logic                        avg_aresetn,
  output logic [4:0]                  avg_log_count,
  output logic                        busy,
  output logic                        done,
  output logic                        sync_err,
  output logic                        irq,
  output logic [RUN_CNT_WIDTH-1:0]    runs_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_SYNC, S_RUN, S_DRAIN
  } state_t;

  localparam logic [FRAME_LEN_LOG-1:0] FRAME_MAX = '1;
  localparam logic [FRAME_LEN_LOG-1:0] FRAME_ONE = FRAME_LEN_LOG'(1);
  localparam logic [RUN_CNT_WIDTH-1:0] RUN_MAX   = '1;
  localparam logic [RUN_CNT_WIDTH-1:0] RUN_ONE   = RUN_CNT_WIDTH'(1);

  state_t                   state_q, state_d;
  logic                     flush_q, flush_d;
  logic [FRAME_LEN_LOG-1:0] frame_q, frame_d;
  logic [RUN_CNT_WIDTH-1:0] runs_q, runs_d;
  logic [RUN_CNT_WIDTH-1:0] num_runs_q, num_runs_d;
  logic [4:0]               log_q, log_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     irq_q, irq_d;
  logic                     avg_rst_q, avg_rst_d;

  logic                     passing, xfer_in, xfer_mon, at_max;
  logic [RUN_CNT_WIDTH-1:0] runs_inc;

  assign passing  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign xfer_in  = S_AXIS_tvalid & S_AXIS_tready;
  assign xfer_mon = mon_tvalid & mon_tready & mon_tlast;
  assign at_max   = (frame_q == FRAME_MAX);
  assign runs_inc = (runs_q == RUN_MAX) ? runs_q : runs_q + RUN_ONE;

  // Stream gating is combinational so RUN/DRAIN add no latency to the averager path.
  always_comb begin
    S_AXIS_tready = 1'b0;
    M_AXIS_tvalid = 1'b0;
    case (state_q)
      S_SYNC:         S_AXIS_tready = 1'b1;
      S_RUN, S_DRAIN: begin
        S_AXIS_tready = M_AXIS_tready;
        M_AXIS_tvalid = S_AXIS_tvalid;
      end
      default: ;
    endcase
  end

  assign M_AXIS_tdata = S_AXIS_tdata;

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    frame_d    = frame_q;
    runs_d     = runs_q;
    num_runs_d = num_runs_q;
    log_d      = log_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start && !cmd_stop) begin
          state_d    = S_FLUSH;
          flush_d    = 1'b0;
          log_d      = cfg_log_count;
          num_runs_d = cfg_num_runs;
          done_d     = 1'b0;
          err_d      = 1'b0;
          runs_d     = '0;
        end
      end
      S_FLUSH: begin
        if (cmd_stop)     state_d = S_IDLE;
        else if (flush_q) state_d = S_SYNC;
        else              flush_d = 1'b1;
      end
      S_SYNC: begin
        if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (xfer_in && S_AXIS_tlast) begin
          state_d = S_RUN;
          frame_d = '0;
        end
      end
      S_RUN, S_DRAIN: begin
        if (xfer_in) begin
          frame_d = frame_q + FRAME_ONE;
          if (at_max != S_AXIS_tlast) err_d = 1'b1;
        end
        if (xfer_mon) runs_d = runs_inc;
        if (state_q == S_RUN) begin
          // A result landing with a stop still ends the run as complete.
          if (xfer_mon && (num_runs_q != '0) && (runs_inc == num_runs_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (cmd_stop) begin
            state_d = S_DRAIN;
          end
        end else if (xfer_in && at_max) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    irq_d     = passing && (state_d == S_IDLE);
    avg_rst_d = (state_d == S_SYNC) || (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      flush_q    <= 1'b0;
      frame_q    <= '0;
      runs_q     <= '0;
      num_runs_q <= '0;
      log_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      avg_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      frame_q    <= frame_d;
      runs_q     <= runs_d;
      num_runs_q <= num_runs_d;
      log_q      <= log_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      avg_rst_q  <= avg_rst_d;
    end
  end

  assign avg_aresetn   = avg_rst_q;
  assign avg_log_count = log_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign sync_err      = err_q;
  assign irq           = irq_q;
  assign runs_done     = runs_q;

endmodule

// File: tb/tb_axis_averager_sequencer.sv
// Randomized bench for axis_averager_sequencer with 16-sample frames; expectations come from
// frame/run arithmetic and a scoreboard of samples that should reach the averager.
module tb_axis_averager_sequencer;

  localparam int DW = 32;
  localparam int FL = 4;
  localparam int RW = 16;
  localparam int FRAME = 1 << FL;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [4:0]    cfg_log_count;
  logic [RW-1:0] cfg_num_runs;
  logic          cmd_start, cmd_stop;
  logic [DW-1:0] S_AXIS_tdata;
  logic          S_AXIS_tvalid, S_AXIS_tlast, S_AXIS_tready;
  logic [DW-1:0] M_AXIS_tdata;
  logic          M_AXIS_tvalid, M_AXIS_tready;
  logic          mon_tvalid, mon_tready, mon_tlast;
  logic          avg_aresetn;
  logic [4:0]    avg_log_count;
  logic          busy, done, sync_err, irq;
  logic [RW-1:0] runs_done;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] exp_q[$];

  axis_averager_sequencer #(
    .AXIS_TDATA_WIDTH(DW), .FRAME_LEN_LOG(FL), .RUN_CNT_WIDTH(RW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_log_count(cfg_log_count), .cfg_num_runs(cfg_num_runs),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tlast(S_AXIS_tlast), .S_AXIS_tready(S_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .avg_aresetn(avg_aresetn), .avg_log_count(avg_log_count),
    .busy(busy), .done(done), .sync_err(sync_err), .irq(irq), .runs_done(runs_done)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Offers one sample until accepted; records whatever the averager side actually receives.
  task automatic push_sample(input logic [DW-1:0] d, input bit last, input bit stall);
    int  guard = 0;
    bit  acc = 0;
    S_AXIS_tdata = d;
    S_AXIS_tlast = last;
    while (!acc && guard < 200) begin
      S_AXIS_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      M_AXIS_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (M_AXIS_tvalid && M_AXIS_tready) out_q.push_back(M_AXIS_tdata);
      acc = S_AXIS_tvalid && S_AXIS_tready;
      @(posedge aclk);
      #1;
      guard++;
    end
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast  = 1'b0;
    M_AXIS_tready = 1'b1;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: sample %h not accepted within 200 cycles", d);
    end
  endtask

  // Pushes frame positions [from, to] of a run-mode frame and records them as expected output.
  task automatic push_frame_range(input int from, input int to, input bit stall);
    for (int i = from; i <= to; i++) begin
      logic [DW-1:0] d = $urandom;
      exp_q.push_back(d);
      push_sample(d, (i == FRAME - 1), stall);
    end
  endtask

  task automatic mon_pulse();
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
    cyc();
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] lg, input logic [RW-1:0] nr);
    int g = 0;
    cfg_log_count = lg;
    cfg_num_runs  = nr;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    while (!avg_aresetn && g < 10) begin
      cyc();
      g++;
    end
    if (!avg_aresetn) begin
      checks++; errors++;
      $display("FAIL sync_timeout: avg_aresetn=%b required 1", avg_aresetn);
    end
    push_sample($urandom, 1'b1, 1'b0);
  endtask

  function automatic bit q_eq();
    if (out_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    aresetn = 1'b0;
    cyc(); cyc();
    S_AXIS_tvalid = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (avg_aresetn !== 1'b0) begin errors++; $display("FAIL rst_avg_aresetn got %b exp 0", avg_aresetn); end
    checks++; if (S_AXIS_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", S_AXIS_tready); end
    checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", M_AXIS_tvalid); end
    checks++; if ({done, sync_err, irq} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {done, sync_err, irq}); end
    checks++; if (runs_done !== '0 || avg_log_count !== '0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", runs_done, avg_log_count); end
    S_AXIS_tvalid = 1'b0;
    aresetn = 1'b1;
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_single_run();
    out_q.delete(); exp_q.delete();
    cfg_log_count = 5'd2; cfg_num_runs = 16'd1;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    S_AXIS_tvalid = 1'b1;
    #1;
    checks++; if (busy !== 1'b1 || avg_aresetn !== 1'b0) begin errors++; $display("FAIL flush1 busy/avg got %b%b exp 10", busy, avg_aresetn); end
    checks++; if (S_AXIS_tready !== 1'b0) begin errors++; $display("FAIL flush1_tready got %b exp 0", S_AXIS_tready); end
    checks++; if (avg_log_count !== 5'd2) begin errors++; $display("FAIL flush_log got %0d exp 2", avg_log_count); end
    cyc();
    checks++; if (avg_aresetn !== 1'b0 || S_AXIS_tready !== 1'b0) begin errors++; $display("FAIL flush2 avg/tready got %b%b exp 00", avg_aresetn, S_AXIS_tready); end
    cyc();
    checks++; if (avg_aresetn !== 1'b1 || S_AXIS_tready !== 1'b1 || M_AXIS_tvalid !== 1'b0) begin
      errors++; $display("FAIL sync_entry avg/tready/tvalid got %b%b%b exp 110", avg_aresetn, S_AXIS_tready, M_AXIS_tvalid); end
    S_AXIS_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) push_sample($urandom, 1'b0, 1'b1);
    push_sample($urandom, 1'b1, 1'b1);
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL sync_drop got %0d samples exp 0", out_q.size()); end
    push_frame_range(0, FRAME - 1, 1'b1);
    checks++; if (q_eq() !== 1'b1) begin errors++; $display("FAIL run1_data got %0d samples exp %0d (or content differs)", out_q.size(), exp_q.size()); end
    checks++; if (sync_err !== 1'b0 || runs_done !== 16'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL run1_state err/runs/busy got %b/%0d/%b exp 0/0/1", sync_err, runs_done, busy); end
    mon_pulse();
    S_AXIS_tvalid = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL run1_end busy/done/irq got %b%b%b exp 011", busy, done, irq); end
    checks++; if (runs_done !== 16'd1 || avg_log_count !== 5'd2) begin errors++; $display("FAIL run1_counts runs/log got %0d/%0d exp 1/2", runs_done, avg_log_count); end
    checks++; if (avg_aresetn !== 1'b0 || S_AXIS_tready !== 1'b0) begin errors++; $display("FAIL run1_gate avg/tready got %b%b exp 00", avg_aresetn, S_AXIS_tready); end
    S_AXIS_tvalid = 1'b0;
    cyc();
    checks++; if (irq !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL run1_irq_pulse irq/done got %b%b exp 01", irq, done); end
  endtask

  task automatic test_stop_drain();
    out_q.delete(); exp_q.delete();
    start_run(5'd3, 16'd0);
    push_frame_range(0, 5, 1'b1);
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %b exp 1", busy); end
    push_frame_range(6, 9, 1'b1);
    mon_pulse();
    push_frame_range(10, FRAME - 1, 1'b1);
    S_AXIS_tvalid = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || irq !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL drain_end busy/irq/done got %b%b%b exp 011", busy, irq, done); end
    checks++; if (S_AXIS_tready !== 1'b0 || M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL drain_gate tready/tvalid got %b%b exp 00", S_AXIS_tready, M_AXIS_tvalid); end
    checks++; if (runs_done !== 16'd1 || avg_log_count !== 5'd3) begin errors++; $display("FAIL drain_counts runs/log got %0d/%0d exp 1/3", runs_done, avg_log_count); end
    S_AXIS_tvalid = 1'b0;
    checks++; if (q_eq() !== 1'b1) begin errors++; $display("FAIL drain_data got %0d samples exp %0d (or content differs)", out_q.size(), exp_q.size()); end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    out_q.delete(); exp_q.delete();
    start_run(5'd1, 16'd0);
    push_frame_range(0, 2, 1'b0);
    d = $urandom;
    S_AXIS_tdata = d; S_AXIS_tlast = 1'b0; S_AXIS_tvalid = 1'b1; M_AXIS_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++; if (S_AXIS_tready !== 1'b0 || M_AXIS_tvalid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] tready/tvalid got %b%b exp 01", i, S_AXIS_tready, M_AXIS_tvalid); end
      checks++; if (M_AXIS_tdata !== d) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, M_AXIS_tdata, d); end
      cyc();
    end
    exp_q.push_back(d);
    push_sample(d, 1'b0, 1'b0);
    push_frame_range(4, FRAME - 1, 1'b1);
    checks++; if (q_eq() !== 1'b1) begin errors++; $display("FAIL bp_data_all got %0d samples exp %0d (or content differs)", out_q.size(), exp_q.size()); end
    checks++; if (sync_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_align err/busy got %b%b exp 01", sync_err, busy); end
  endtask

  task automatic test_reset_midrun();
    mon_pulse();
    push_frame_range(0, 1, 1'b0);
    checks++; if (runs_done !== 16'd1) begin errors++; $display("FAIL pre_rst_runs got %0d exp 1", runs_done); end
    aresetn = 1'b0; S_AXIS_tvalid = 1'b1; M_AXIS_tready = 1'b1;
    cyc();
    checks++; if (busy !== 1'b0 || avg_aresetn !== 1'b0) begin errors++; $display("FAIL midrst busy/avg got %b%b exp 00", busy, avg_aresetn); end
    checks++; if (S_AXIS_tready !== 1'b0 || M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL midrst tready/tvalid got %b%b exp 00", S_AXIS_tready, M_AXIS_tvalid); end
    checks++; if (runs_done !== '0 || avg_log_count !== '0 || {done, sync_err, irq} !== 3'b000) begin
      errors++; $display("FAIL midrst counts runs/log/flags got %0d/%0d/%b exp 0/0/000", runs_done, avg_log_count, {done, sync_err, irq}); end
    aresetn = 1'b1; S_AXIS_tvalid = 1'b0;
    cyc();
  endtask

  task automatic test_cfg_freeze();
    cfg_log_count = 5'd7; cfg_num_runs = 16'd3;
    cmd_start = 1'b1; cmd_stop = 1'b1;
    cyc();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    checks++; if (busy !== 1'b0 || avg_aresetn !== 1'b0 || avg_log_count !== 5'd0) begin
      errors++; $display("FAIL startstop busy/avg/log got %b%b/%0d exp 00/0", busy, avg_aresetn, avg_log_count); end
    out_q.delete(); exp_q.delete();
    start_run(5'd2, 16'd2);
    cfg_log_count = 5'd5; cfg_num_runs = 16'd1;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    mon_pulse();
    checks++; if (busy !== 1'b1 || runs_done !== 16'd1 || avg_log_count !== 5'd2) begin
      errors++; $display("FAIL freeze busy/runs/log got %b/%0d/%0d exp 1/1/2", busy, runs_done, avg_log_count); end
    cmd_stop = 1'b1;
    mon_pulse();
    cmd_stop = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b1 || irq !== 1'b1 || runs_done !== 16'd2) begin
      errors++; $display("FAIL complete_prio busy/done/irq/runs got %b%b%b/%0d exp 011/2", busy, done, irq, runs_done); end
    cyc();
  endtask

  task automatic test_sync_err();
    int g = 0;
    out_q.delete(); exp_q.delete();
    start_run(5'd0, 16'd0);
    for (int i = 0; i < 10; i++) push_sample($urandom, (i == 9), 1'b1);
    checks++; if (sync_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL sync_err_set err/busy got %b%b exp 11", sync_err, busy); end
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    for (int i = 10; i < FRAME; i++) push_sample($urandom, (i == FRAME - 1), 1'b1);
    checks++; if (busy !== 1'b0 || sync_err !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL sync_err_sticky busy/err/done got %b%b%b exp 011", busy, sync_err, done); end
    cfg_log_count = 5'd4;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    checks++; if (sync_err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_clears err/done got %b%b exp 00", sync_err, done); end
    while (!avg_aresetn && g < 10) begin cyc(); g++; end
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    checks++; if (busy !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL sync_stop busy/irq got %b%b exp 00", busy, irq); end
    cyc();
  endtask

  task automatic test_random_runs();
    for (int it = 0; it < 3; it++) begin
      int nr = $urandom_range(2, 4);
      logic [4:0] lg = 5'($urandom_range(0, 31));
      int mons = 0;
      out_q.delete(); exp_q.delete();
      start_run(lg, 16'(nr));
      while (mons < nr) begin
        push_frame_range(0, FRAME - 1, 1'b1);
        mon_pulse();
        mons++;
        checks++; if (busy !== (mons < nr) || runs_done !== 16'(mons)) begin
          errors++; $display("FAIL rnd[%0d] busy/runs got %b/%0d exp %b/%0d", it, busy, runs_done, (mons < nr), mons); end
      end
      checks++; if (done !== 1'b1 || avg_log_count !== lg) begin errors++; $display("FAIL rnd_end[%0d] done/log got %b/%0d exp 1/%0d", it, done, avg_log_count, lg); end
      checks++; if (q_eq() !== 1'b1) begin errors++; $display("FAIL rnd_data[%0d] got %0d samples exp %0d (or content differs)", it, out_q.size(), exp_q.size()); end
      cyc();
    end
  endtask

  initial begin
    aresetn = 1'b0; cfg_log_count = '0; cfg_num_runs = '0;
    cmd_start = 1'b0; cmd_stop = 1'b0;
    S_AXIS_tdata = '0; S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0;
    M_AXIS_tready = 1'b1;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    test_reset();
    test_single_run();
    test_stop_drain();
    test_backpressure();
    test_reset_midrun();
    test_cfg_freeze();
    test_sync_err();
    test_random_runs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
